// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers: write-back select
// encodings, the NOP encoding and the default field widths.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int SEL_W  = 2;
    localparam int TNEW_W = 2;

    // memToReg write-back select encodings
    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_DM  = 2'd1;
    localparam logic [1:0] SEL_PC8 = 2'd2;

    localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/pipe_stage_reg_sat_dec.sv
// Saturating decrementer: y = a - 1, clamped at 0.
module sat_dec #(
    parameter int W = 2
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    always_comb begin
        y = (a == '0) ? '0 : a - W'(1);
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall, flush, valid tracking, Tnew aging
// and a saturating stall-cycle counter.
module pipe_stage_reg #(
    parameter int DATA_W           = pipe_pkg::DATA_W,
    parameter int ADDR_W           = pipe_pkg::ADDR_W,
    parameter int SEL_W            = pipe_pkg::SEL_W,
    parameter int TNEW_W           = pipe_pkg::TNEW_W,
    parameter int CNT_W            = 16,
    parameter bit KEEP_PC_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] instr_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] dm_in,
    input  logic [ADDR_W-1:0] wa_in,
    input  logic [SEL_W-1:0]  sel_in,
    input  logic [TNEW_W-1:0] tnew_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] instr_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] dm_out,
    output logic [ADDR_W-1:0] wa_out,
    output logic [SEL_W-1:0]  sel_out,
    output logic [TNEW_W-1:0] tnew_out,
    output logic [CNT_W-1:0]  stall_cnt
);

    import pipe_pkg::NOP_INSTR;

    logic [TNEW_W-1:0] tnew_dec;

    sat_dec #(.W(TNEW_W)) u_tnew_dec (
        .a (tnew_in),
        .y (tnew_dec)
    );

    // NOTE: all state uses non-blocking assignments so every field samples
    // pre-edge values; blocking here would create order-dependent behavior.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            pc_out    <= '0;
            instr_out <= '0;
            alu_out   <= '0;
            dm_out    <= '0;
            wa_out    <= '0;
            sel_out   <= '0;
            tnew_out  <= '0;
            stall_cnt <= '0;
        end else if (flush) begin
            // Bubble: no GRF write, no pending result; stall_cnt untouched.
            valid_out <= 1'b0;
            pc_out    <= KEEP_PC_ON_FLUSH ? pc_in : '0;
            instr_out <= DATA_W'(NOP_INSTR);
            alu_out   <= '0;
            dm_out    <= '0;
            wa_out    <= '0;
            sel_out   <= '0;
            tnew_out  <= '0;
        end else if (stall) begin
            if (stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end else begin
            valid_out <= valid_in;
            pc_out    <= pc_in;
            instr_out <= instr_in;
            alu_out   <= alu_in;
            dm_out    <= dm_in;
            sel_out   <= sel_in;
            // A non-valid slot must never request a GRF write.
            wa_out    <= valid_in ? wa_in : '0;
            tnew_out  <= valid_in ? tnew_dec : '0;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: one default instance and
// one with CNT_W=2 / KEEP_PC_ON_FLUSH=0 sharing the same stimulus.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset, stall, flush, valid_in;
    logic [31:0] pc_in, instr_in, alu_in, dm_in;
    logic [4:0]  wa_in;
    logic [1:0]  sel_in, tnew_in;

    logic        valid_a, valid_b;
    logic [31:0] pc_a, instr_a, alu_a, dm_a, pc_b, instr_b, alu_b, dm_b;
    logic [4:0]  wa_a, wa_b;
    logic [1:0]  sel_a, tnew_a, sel_b, tnew_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg u_a (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_in(valid_in), .pc_in(pc_in), .instr_in(instr_in),
        .alu_in(alu_in), .dm_in(dm_in), .wa_in(wa_in), .sel_in(sel_in),
        .tnew_in(tnew_in),
        .valid_out(valid_a), .pc_out(pc_a), .instr_out(instr_a),
        .alu_out(alu_a), .dm_out(dm_a), .wa_out(wa_a), .sel_out(sel_a),
        .tnew_out(tnew_a), .stall_cnt(cnt_a)
    );

    pipe_stage_reg #(.CNT_W(2), .KEEP_PC_ON_FLUSH(1'b0)) u_b (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_in(valid_in), .pc_in(pc_in), .instr_in(instr_in),
        .alu_in(alu_in), .dm_in(dm_in), .wa_in(wa_in), .sel_in(sel_in),
        .tnew_in(tnew_in),
        .valid_out(valid_b), .pc_out(pc_b), .instr_out(instr_b),
        .alu_out(alu_b), .dm_out(dm_b), .wa_out(wa_b), .sel_out(sel_b),
        .tnew_out(tnew_b), .stall_cnt(cnt_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [4:0] wa, input logic [1:0] tn);
        valid_in = v;
        pc_in    = pc;
        instr_in = ins;
        wa_in    = wa;
        tnew_in  = tn;
        alu_in   = pc ^ 32'h5555_0000;
        dm_in    = pc ^ 32'h0000_aaaa;
        sel_in   = pipe_pkg::SEL_DM;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 64'(valid_a), 0);
        check({tag, "_pc"},    64'(pc_a),    0);
        check({tag, "_instr"}, 64'(instr_a), 0);
        check({tag, "_alu"},   64'(alu_a),   0);
        check({tag, "_dm"},    64'(dm_a),    0);
        check({tag, "_wa"},    64'(wa_a),    0);
        check({tag, "_sel"},   64'(sel_a),   0);
        check({tag, "_tnew"},  64'(tnew_a),  0);
        check({tag, "_cnt"},   64'(cnt_a),   0);
        check({tag, "_cnt_b"}, 64'(cnt_b),   0);
        check({tag, "_pc_b"},  64'(pc_b),    0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 32'hdead_beef, 32'h1111_2222, 5'd7, 2'd3);

        // Reset for two edges with busy inputs
        step(); check_zero("rst1");
        step(); check_zero("rst2");

        // Plain load
        reset = 1'b0;
        drive(1'b1, 32'h3000, 32'h2401_0005, 5'd1, 2'd2);
        step();
        check("ld_pc",    64'(pc_a),    64'h3000);
        check("ld_instr", 64'(instr_a), 64'h2401_0005);
        check("ld_alu",   64'(alu_a),   64'h5555_3000);
        check("ld_dm",    64'(dm_a),    64'h0000_9aaa);
        check("ld_wa",    64'(wa_a),    1);
        check("ld_sel",   64'(sel_a),   1);
        check("ld_tnew",  64'(tnew_a),  1);
        check("ld_valid", 64'(valid_a), 1);
        check("ld_cnt",   64'(cnt_a),   0);

        drive(1'b1, 32'h3004, 32'h8c02_0000, 5'd2, 2'd3);
        step();
        check("ld2_pc",   64'(pc_a),   64'h3004);
        check("ld2_tnew", 64'(tnew_a), 2);

        // Three stall cycles with changing inputs
        stall = 1'b1;
        drive(1'b1, 32'h3008, 32'h0000_0020, 5'd3, 2'd1);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("stl_pc",  64'(pc_a),  64'h3004);
            check("stl_cnt", 64'(cnt_a), 64'(i));
        end
        check("stl_tnew",  64'(tnew_a),  2);
        check("stl_wa",    64'(wa_a),    2);
        check("stl_instr", 64'(instr_a), 64'h8c02_0000);
        check("stl_cnt_b", 64'(cnt_b),   3);

        stall = 1'b0;
        step();
        check("rel_pc",   64'(pc_a),   64'h3008);
        check("rel_tnew", 64'(tnew_a), 0);
        check("rel_wa",   64'(wa_a),   3);
        check("rel_cnt",  64'(cnt_a),  3);

        // Flush and stall together: flush wins, counter frozen
        drive(1'b1, 32'h300c, 32'h0000_1234, 5'd5, 2'd2);
        step();
        check("ld3_wa", 64'(wa_a), 5);
        stall = 1'b1; flush = 1'b1;
        drive(1'b1, 32'h300c, 32'h0000_5678, 5'd6, 2'd2);
        step();
        check("fs_valid", 64'(valid_a), 0);
        check("fs_wa",    64'(wa_a),    0);
        check("fs_instr", 64'(instr_a), 0);
        check("fs_alu",   64'(alu_a),   0);
        check("fs_dm",    64'(dm_a),    0);
        check("fs_sel",   64'(sel_a),   0);
        check("fs_tnew",  64'(tnew_a),  0);
        check("fs_pc",    64'(pc_a),    64'h300c);
        check("fs_cnt",   64'(cnt_a),   3);
        check("fs_pc_b",  64'(pc_b),    0);

        // Flush alone takes the incoming PC, not the held one
        stall = 1'b0;
        drive(1'b1, 32'h3014, 32'h0000_9999, 5'd9, 2'd3);
        step();
        check("fl_pc",    64'(pc_a),    64'h3014);
        check("fl_valid", 64'(valid_a), 0);
        check("fl_pc_b",  64'(pc_b),    0);
        flush = 1'b0;

        // Non-valid slot and Tnew floor
        drive(1'b0, 32'h3018, 32'h0000_4444, 5'd31, 2'd2);
        step();
        check("inv_wa",    64'(wa_a),    0);
        check("inv_tnew",  64'(tnew_a),  0);
        check("inv_valid", 64'(valid_a), 0);
        check("inv_pc",    64'(pc_a),    64'h3018);
        drive(1'b1, 32'h301c, 32'h0000_4444, 5'd4, 2'd0);
        step();
        check("t0_tnew",  64'(tnew_a),  0);
        check("t0_wa",    64'(wa_a),    4);
        check("t0_valid", 64'(valid_a), 1);

        // Six more stalls: narrow counter saturates, wide one keeps counting
        stall = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("sat_cnt_b", 64'(cnt_b), 3);
        check("sat_cnt_a", 64'(cnt_a), 9);
        check("sat_pc",    64'(pc_a),  64'h301c);

        // Reset while stalled clears everything, counters included
        reset = 1'b1;
        step();
        check_zero("rst_stl");
        reset = 1'b0; stall = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
